// File: rtl/psum_accumulator.sv
// Pipelined partial-sum accumulator: reduces CH lanes per beat, then folds the
// beat sum into an ACC_W accumulator (plain add or shift-and-add) per framed group.
module psum_accumulator #(
  parameter int CH     = 4,
  parameter int IN_W   = 4,
  parameter int ACC_W  = 16,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [CH*IN_W-1:0]   in_data,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic                 shift_en,
  output logic                 out_valid,
  output logic [ACC_W-1:0]     out_data,
  output logic                 out_ovf
);

  localparam int SUM_W = IN_W + $clog2(CH);
  // Two guard bits hold acc<<1 plus a beat sum exactly, so overflow is detectable.
  localparam int EXT_W = ACC_W + 2;

  typedef enum logic {IDLE, ACCUM} state_t;

  function automatic logic signed [SUM_W-1:0] ext_lane(input logic [IN_W-1:0] v);
    logic pad;
    pad = (SIGNED != 0) & v[IN_W-1];
    return {{(SUM_W-IN_W){pad}}, v};
  endfunction

  function automatic logic signed [EXT_W-1:0] ext_sum(input logic signed [SUM_W-1:0] v);
    logic pad;
    pad = (SIGNED != 0) & v[SUM_W-1];
    return {{(EXT_W-SUM_W){pad}}, v};
  endfunction

  function automatic logic signed [EXT_W-1:0] ext_acc(input logic [ACC_W-1:0] v);
    logic pad;
    pad = (SIGNED != 0) & v[ACC_W-1];
    return {{2{pad}}, v};
  endfunction

  function automatic logic ovf_check(input logic signed [EXT_W-1:0] v);
    logic [2:0] top;
    top = v[EXT_W-1:ACC_W-1];
    if (SIGNED != 0) return !((&top) || !(|top));
    else             return |v[EXT_W-1:ACC_W];
  endfunction

  function automatic logic [ACC_W-1:0] saturate(input logic neg);
    if (SIGNED != 0)
      return neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      return {ACC_W{1'b1}};
  endfunction

  logic signed [SUM_W-1:0] lane_sum;
  logic signed [SUM_W-1:0] sum_p1;
  logic                    vld_p1, first_p1, last_p1, shift_p1;
  logic [ACC_W-1:0]        acc_p2;
  logic                    ovf_p2;
  state_t                  state;

  logic                    new_group;
  logic signed [EXT_W-1:0] base, exact;
  logic                    ovf_now;
  logic [ACC_W-1:0]        acc_nxt;
  logic                    ovf_nxt;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < CH; i++)
      lane_sum = lane_sum + ext_lane(in_data[i*IN_W +: IN_W]);
  end

  always_comb begin
    new_group = first_p1 || (state == IDLE);
    if (new_group)     base = '0;
    else if (shift_p1) base = ext_acc(acc_p2) <<< 1;
    else               base = ext_acc(acc_p2);
    exact   = base + ext_sum(sum_p1);
    ovf_now = ovf_check(exact);
    acc_nxt = ((SAT != 0) && ovf_now) ? saturate(exact[EXT_W-1]) : exact[ACC_W-1:0];
    ovf_nxt = ovf_now | (ovf_p2 & !new_group);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      sum_p1    <= '0;
      first_p1  <= 1'b0;
      last_p1   <= 1'b0;
      shift_p1  <= 1'b0;
      acc_p2    <= '0;
      ovf_p2    <= 1'b0;
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      // stage 1: lane reduction
      vld_p1 <= in_valid;
      if (in_valid) begin
        sum_p1   <= lane_sum;
        first_p1 <= in_first;
        last_p1  <= in_last;
        shift_p1 <= shift_en;
      end
      // stage 2: accumulate and publish
      out_valid <= 1'b0;
      if (vld_p1) begin
        acc_p2 <= acc_nxt;
        ovf_p2 <= ovf_nxt;
        state  <= last_p1 ? IDLE : ACCUM;
        if (last_p1) begin
          out_valid <= 1'b1;
          out_data  <= acc_nxt;
          out_ovf   <= ovf_nxt;
        end
      end
    end
  end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Parametrised partial-sum accumulator for the CIM datapath, generalising the 4-bit combinational adder into a pipelined multi-lane reduce-and-accumulate unit. Each valid beat reduces CH lanes of IN_W-bit operands through a registered adder tree. The beat sum is then folded into an ACC_W-bit accumulator, in plain-add or shift-and-add (bit-serial) mode. Framing comes from first/last markers. The block sits between the CIM macro column outputs and the output buffer.

## Interface
- CH, 4, number of input lanes (power of two, >= 2)
- IN_W, 4, width of each lane operand
- ACC_W, 16, accumulator/result width; must be >= IN_W + log2(CH) + 1
- SIGNED, 0, 1 = lanes and accumulator are two's complement; 0 = unsigned
- SAT, 0, 1 = saturate on overflow; 0 = wrap modulo 2^ACC_W
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  beat present this cycle
- in_data  input  CH*IN_W  lane i at bits [i*IN_W +: IN_W]
- in_first  input  1  beat starts a new group (qualified by in_valid)
- in_last  input  1  beat ends the group (qualified by in_valid)
- shift_en  input  1  1 = acc <- (acc<<1) + sum; 0 = acc <- acc + sum (ignored on first beat)
- out_valid  output  1  one-cycle pulse, group result available
- out_data  output  ACC_W  group result, held until next out_valid
- out_ovf  output  1  group overflowed, held with out_data

## Operation
- Stage 1: on in_valid, register sum1 = sum of CH lanes, width SUM_W = IN_W + log2(CH), sign- or zero-extended per SIGNED. Also register valid1, first1, last1, shift1. The tree must not lose carries.
- Stage 2 FSM, states IDLE and ACCUM:
  - On valid1, base = 0 if (first1 or state==IDLE); otherwise base = shift_en-selected acc<<1 or acc.
  - acc <= base + ext(sum1).
  - The sticky ovf flag clears on a new group and sets when the exact result does not fit ACC_W (unsigned: carry-out; signed: sign overflow).
  - SAT=1: on overflow acc clamps to max (unsigned 2^ACC_W-1; signed 2^(ACC_W-1)-1) or min (0 or -2^(ACC_W-1)) per the direction of the true result.
  - SAT=0: acc wraps.
  - Next state is IDLE if last1, else ACCUM.
- On valid1 and last1: out_data <= new acc, out_ovf <= new ovf, out_valid <= 1. Otherwise out_valid <= 0 and out_data/out_ovf hold.
- Boundaries:
  - in_first and in_last on the same beat: single-beat group, out_data = sum.
  - in_first while in ACCUM: the open group is abandoned silently and a new group starts.
  - Beat without in_first while in IDLE: implicit group start.
  - in_valid low: no state change; acc and ovf hold (bubbles allowed anywhere).
  - in_first/in_last/shift_en are don't-care when in_valid is low.
  - Back-to-back groups (last at edge k, first at edge k+1) are supported at full rate.
- Reset (rst_n low at an edge): all pipeline registers, acc, ovf, out_data, out_ovf, out_valid go to 0 and state goes to IDLE. Reset mid-group discards the group and produces no out_valid.

## Timing
- Throughput: one beat per cycle, no backpressure.
- Beat sampled at rising edge k → stage-1 registers load at edge k → acc/out registers load at edge k+1.
- out_valid is high for the cycle between edges k+1 and k+2.
- All outputs are registered; no combinational input→output path.
- Reset values: out_valid=0, out_data=0, out_ovf=0.
- Inputs are sampled only at rising edges. The bench drives on posedge and checks on negedge.

## Test plan
- Single beat, CH=4, IN_W=4, ACC_W=8, SIGNED=0: lanes {15,15,15,15}, first=last=1 at edge k → out_valid during cycle k+1, out_data=60, out_ovf=0.
- Add mode: 3 beats of {1,2,3,4}, first on beat 0, last on beat 2, gaps of 2 idle cycles between beats → out_data=30, exactly one out_valid pulse.
- Shift mode: beat sums 1,0,1 with shift_en=1 on beats 1 and 2 → out_data=5. Immediately follow with a back-to-back single-beat group of sum 7 → pulses on consecutive cycles, out_data 5 then 7.
- Overflow, ACC_W=8: 5 beats of {15,15,15,15} (total 300) → SAT=0: out_data=44, out_ovf=1; SAT=1: out_data=255, out_ovf=1. The next group of sum 3 → out_ovf=0.
- Signed, SIGNED=1, ACC_W=8: lanes {-8,-8,-8,-8} then {7,7,7,7} → out_data=8'hFC (−4). Five beats of {-8,-8,-8,-8} with SAT=1 → out_data=8'h80, out_ovf=1.
- Reset and abort:
  - rst_n low for 1 cycle mid-group → no out_valid, all outputs 0; the following group of sum 10 → out_data=10.
  - in_first mid-group → only the new group's sum is reported.
- Randomised: 100 groups of random length 1–8, random bubbles and modes, checked against a reference model.
